// File: rtl/tmr_regfile_pkg.sv
// Shared definitions for the triple-redundant register file.
// Holds default geometry constants, the scrubber state encoding, the
// hardwired-zero register index and the 2-of-3 majority helper.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NREAD_DEF = 2;
    localparam int CNT_W_DEF = 8;
    localparam int ZERO_REG  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FIX   = 2'd2
    } scrub_state_e;

    // Single-bit 2-of-3 majority: the value held by at least two copies.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_regfile_if.sv
// Register-file access bus: one write port plus NREAD packed read ports.
// master drives addresses/write data, slave returns voted data and
// per-port copy-disagreement flags.
interface tmr_regfile_if
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int AW    = $clog2(DEPTH_DEF),
    parameter int NREAD = NREAD_DEF
);
    logic                    we;
    logic [AW-1:0]           waddr;
    logic [XLEN-1:0]         wdata;
    logic [NREAD*AW-1:0]     raddr;
    logic [NREAD*XLEN-1:0]   rdata;
    logic [NREAD-1:0]        rd_mismatch;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata, rd_mismatch
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata, rd_mismatch
    );
endinterface

// File: rtl/tmr_regfile_voter.sv
// XLEN-wide bitwise 2-of-3 majority voter with a disagreement flag.
// mismatch is set whenever any copy differs from the others, even when
// the vote itself still recovers the correct value.
module tmr_voter
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] copy0,
    input  logic [XLEN-1:0] copy1,
    input  logic [XLEN-1:0] copy2,
    output logic [XLEN-1:0] voted,
    output logic            mismatch
);

    // Per-bit majority across the three copies.
    always_comb begin
        voted = {XLEN{1'b0}};
        for (int b = 0; b < XLEN; b++) begin
            voted[b] = maj3(copy0[b], copy1[b], copy2[b]);
        end
    end

    assign mismatch = (copy0 != copy1) || (copy1 != copy2);

endmodule

// File: rtl/tmr_regfile.sv
// Triple-redundant register file with voted combinational reads, one
// synchronous write port, a fault-injection hook and a background scrubber
// that rewrites entries whose copies disagree.
// Optional build macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
// Entry 0 is never written, so it always votes to zero with no mismatch.
module tmr_regfile
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH),
    parameter int NREAD = NREAD_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_in,
    tmr_regfile_if.slave     bus,
    input  logic             scrub_en,
    output logic             scrub_busy,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             inj_en,
    input  logic [1:0]       inj_copy,
    input  logic [AW-1:0]    inj_addr,
    input  logic [XLEN-1:0]  inj_mask
);

    localparam int NCOPY = 3;

    logic [XLEN-1:0]  mem_r [NCOPY][DEPTH];

    scrub_state_e     state_r;
    scrub_state_e     state_next_s;
    logic [AW-1:0]    ptr_r;
    logic [AW-1:0]    ptr_wrap_s;
    logic             ptr_adv_s;
    logic             fix_wr_s;
    logic             cnt_inc_s;
    logic             wr_at_ptr_s;
    logic [CNT_W-1:0] err_cnt_r;
    logic             scrub_busy_r;

    logic [XLEN-1:0]  scrub_voted_s;
    logic             scrub_mm_s;

    logic [AW-1:0]    rd_addr_s  [NREAD];
    logic [XLEN-1:0]  rd_voted_s [NREAD];
    logic [NREAD-1:0] rd_mm_s;

    // ------------------------------------------------------------------
    // Read ports: one voter per port, addressed straight from the bus.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        assign rd_addr_s[k] = bus.raddr[k*AW +: AW];

        tmr_voter #(.XLEN(XLEN)) u_voter (
            .copy0    (mem_r[0][rd_addr_s[k]]),
            .copy1    (mem_r[1][rd_addr_s[k]]),
            .copy2    (mem_r[2][rd_addr_s[k]]),
            .voted    (rd_voted_s[k]),
            .mismatch (rd_mm_s[k])
        );
    end

    // Scrubber voter looks at the entry under the scrub pointer.
    tmr_voter #(.XLEN(XLEN)) u_scrub_voter (
        .copy0    (mem_r[0][ptr_r]),
        .copy1    (mem_r[1][ptr_r]),
        .copy2    (mem_r[2][ptr_r]),
        .voted    (scrub_voted_s),
        .mismatch (scrub_mm_s)
    );

    // Pack voted read data; optionally forward the in-flight write.
    always_comb begin
        bus.rdata       = {(NREAD*XLEN){1'b0}};
        bus.rd_mismatch = {NREAD{1'b0}};
        for (int k = 0; k < NREAD; k++) begin
            bus.rdata[k*XLEN +: XLEN] = rd_voted_s[k];
            bus.rd_mismatch[k]        = rd_mm_s[k];
`ifdef RF_BYPASS_EN
            // Forwarding is held off during reset so reads stay zero.
            if (rst_in && bus.we && (bus.waddr == rd_addr_s[k]) &&
                (rd_addr_s[k] != {AW{1'b0}})) begin
                bus.rdata[k*XLEN +: XLEN] = bus.wdata;
                bus.rd_mismatch[k]        = 1'b0;
            end else begin
                bus.rdata[k*XLEN +: XLEN] = rd_voted_s[k];
                bus.rd_mismatch[k]        = rd_mm_s[k];
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Scrubber control
    // ------------------------------------------------------------------
    assign wr_at_ptr_s = bus.we && (bus.waddr == ptr_r);

    // Next scrub pointer: walk 1..DEPTH-1 and skip the zero register.
    always_comb begin
        if (ptr_r == AW'(DEPTH - 1)) begin
            ptr_wrap_s = AW'(1);
        end else begin
            ptr_wrap_s = ptr_r + AW'(1);
        end
    end

    // Scrubber next-state and per-cycle action decode.
    always_comb begin
        state_next_s = state_r;
        ptr_adv_s    = 1'b0;
        fix_wr_s     = 1'b0;
        cnt_inc_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (scrub_en) begin
                    state_next_s = S_CHECK;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CHECK: begin
                // A functional write to the pointer repairs the entry itself.
                if (scrub_mm_s && !wr_at_ptr_s) begin
                    state_next_s = S_FIX;
                end else begin
                    ptr_adv_s    = 1'b1;
                    state_next_s = scrub_en ? S_CHECK : S_IDLE;
                end
            end
            S_FIX: begin
                // The fix always completes, even if scrub_en has dropped.
                fix_wr_s     = 1'b1;
                cnt_inc_s    = !wr_at_ptr_s;
                ptr_adv_s    = 1'b1;
                state_next_s = scrub_en ? S_CHECK : S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Scrubber state, pointer, saturating correction counter, busy flag.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= S_IDLE;
            ptr_r        <= AW'(1);
            err_cnt_r    <= {CNT_W{1'b0}};
            scrub_busy_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            scrub_busy_r <= (state_next_s != S_IDLE);
            if (ptr_adv_s) begin
                ptr_r <= ptr_wrap_s;
            end
            if (cnt_inc_s && (err_cnt_r != {CNT_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
        end
    end

    assign scrub_busy = scrub_busy_r;
    assign err_cnt    = err_cnt_r;

    // ------------------------------------------------------------------
    // Storage: per-entry priority functional write > scrub fix > injection.
    // ------------------------------------------------------------------
    // Update all three copies of every non-zero entry.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int c = 0; c < NCOPY; c++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_r[c][i] <= {XLEN{1'b0}};
                end
            end
        end else begin
            for (int c = 0; c < NCOPY; c++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i != ZERO_REG) begin
                        if (bus.we && (bus.waddr == AW'(i))) begin
                            mem_r[c][i] <= bus.wdata;
                        end else if (fix_wr_s && (ptr_r == AW'(i))) begin
                            mem_r[c][i] <= scrub_voted_s;
                        end else if (inj_en && (inj_copy == 2'(c)) &&
                                     (inj_addr == AW'(i))) begin
                            mem_r[c][i] <= mem_r[c][i] ^ inj_mask;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tmr_regfile.sv
// Self-checking bench for tmr_regfile: directed vector table, hand-written
// scrubber/reset sequences, and a randomized phase checked against a
// three-copy array model that votes by counting ones per bit.
module tb_tmr_regfile;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NREAD = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_in;
    logic             scrub_en;
    logic             scrub_busy;
    logic [CNT_W-1:0] err_cnt;
    logic             inj_en;
    logic [1:0]       inj_copy;
    logic [AW-1:0]    inj_addr;
    logic [XLEN-1:0]  inj_mask;

    tmr_regfile_if #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD)) bus ();

    tmr_regfile #(
        .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NREAD(NREAD), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .bus        (bus),
        .scrub_en   (scrub_en),
        .scrub_busy (scrub_busy),
        .err_cnt    (err_cnt),
        .inj_en     (inj_en),
        .inj_copy   (inj_copy),
        .inj_addr   (inj_addr),
        .inj_mask   (inj_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [XLEN-1:0] m_mem [3][DEPTH];
    int              exp_err;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ie;
        logic [1:0]  icopy;
        logic [4:0]  iaddr;
        logic [31:0] imask;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        m0;
        logic        m1;
    } vec_t;

    vec_t vec [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int k);
        return bus.rdata[k*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we    = 1'b0;
        bus.waddr = 5'd0;
        bus.wdata = 32'd0;
        inj_en    = 1'b0;
        inj_copy  = 2'd0;
        inj_addr  = 5'd0;
        inj_mask  = 32'd0;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        bus.raddr = {a1, a0};
    endtask

    // Model: majority by counting ones in each bit column.
    function automatic logic [31:0] m_vote(input int a);
        logic [31:0] r;
        int ones;
        r = 32'd0;
        for (int b = 0; b < 32; b++) begin
            ones = 0;
            for (int c = 0; c < 3; c++) ones += int'(m_mem[c][a][b]);
            r[b] = (ones >= 2);
        end
        return r;
    endfunction

    function automatic logic m_mm(input int a);
        return !((m_mem[0][a] == m_mem[1][a]) && (m_mem[1][a] == m_mem[2][a]));
    endfunction

    task automatic m_clear();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < DEPTH; a++) m_mem[c][a] = 32'd0;
        exp_err = 0;
    endtask

    // Model of one clock edge with the scrubber idle.
    task automatic m_step(input logic we, input int wa, input logic [31:0] wd,
                          input logic ie, input int ic, input int ia, input logic [31:0] im);
        if (ie && ic < 3 && ia != 0 && !(we && wa == ia)) m_mem[ic][ia] ^= im;
        if (we && wa != 0)
            for (int c = 0; c < 3; c++) m_mem[c][wa] = wd;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_in   = 1'b0;
        scrub_en = 1'b0;
        idle_inputs();
        set_ra(5'd5, 5'd7);
        #1;
        check({tag, "_rdata"}, {32'd0, bus.rdata}, 64'd0);
        check({tag, "_mm"}, {62'd0, bus.rd_mismatch}, 64'd0);
        check({tag, "_busy"}, {63'd0, scrub_busy}, 64'd0);
        check({tag, "_errcnt"}, {56'd0, err_cnt}, 64'd0);
        @(negedge clk);
        rst_in = 1'b1;
        m_clear();
        tick();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (!scrub_busy) break;
            tick();
        end
        check({tag, "_idle"}, {63'd0, scrub_busy}, 64'd0);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic inject(input logic [1:0] c, input logic [4:0] a, input logic [31:0] m);
        inj_en = 1'b1; inj_copy = c; inj_addr = a; inj_mask = m;
        tick();
        inj_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got;
        int fixes;
        int a;
        int nmm;
        logic [31:0] ev;
        logic        em;

        rst_in   = 1'b0;
        scrub_en = 1'b0;
        idle_inputs();
        set_ra(5'd0, 5'd0);
        repeat (2) @(posedge clk);

        // ---------------- reset state and directed vector table -----------
        do_reset("rst0");

        vec[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 2'd0, 5'd0,  32'h0,
                    5'd5,  5'd0,  32'hDEADBEEF, 32'h0,       1'b0, 1'b0};
        vec[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 2'd0, 5'd0,  32'h0,
                    5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vec[2]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 2'd0, 5'd0,  32'h0,
                    5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0};
        vec[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 2'd1, 5'd7,  32'h000000FF,
                    5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b1};
        vec[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 2'd3, 5'd5,  32'hFFFFFFFF,
                    5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vec[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 2'd0, 5'd0,  32'h00000001,
                    5'd0,  5'd7,  32'h0,        32'hA5A5A5A5, 1'b0, 1'b1};
        vec[6]  = '{1'b1, 5'd9,  32'h12345678, 1'b1, 2'd2, 5'd9,  32'h000000FF,
                    5'd9,  5'd7,  32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b1};
        vec[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 2'd0, 5'd7,  32'h0000FF00,
                    5'd7,  5'd9,  32'hA5A5A5A5, 32'h12345678, 1'b1, 1'b0};
        vec[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 2'd2, 5'd7,  32'h000000FF,
                    5'd7,  5'd5,  32'hA5A5A55A, 32'hDEADBEEF, 1'b1, 1'b0};
        vec[9]  = '{1'b1, 5'd7,  32'h0,        1'b0, 2'd0, 5'd0,  32'h0,
                    5'd7,  5'd31, 32'h0,        32'h0,        1'b0, 1'b0};
        vec[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 2'd0, 5'd0,  32'h0,
                    5'd31, 5'd1,  32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};
        vec[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 2'd0, 5'd31, 32'hFFFFFFFF,
                    5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1};
        vec[12] = '{1'b1, 5'd5,  32'hCAFEF00D, 1'b1, 2'd1, 5'd31, 32'hFFFFFFFF,
                    5'd5,  5'd31, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1};

        for (int i = 0; i < 13; i++) begin
            bus.we    = vec[i].we;
            bus.waddr = vec[i].waddr;
            bus.wdata = vec[i].wdata;
            inj_en    = vec[i].ie;
            inj_copy  = vec[i].icopy;
            inj_addr  = vec[i].iaddr;
            inj_mask  = vec[i].imask;
            set_ra(vec[i].ra0, vec[i].ra1);
            tick();
            idle_inputs();
            #1;
            check($sformatf("vec%0d_rd0", i), {32'd0, rd(0)}, {32'd0, vec[i].e0});
            check($sformatf("vec%0d_rd1", i), {32'd0, rd(1)}, {32'd0, vec[i].e1});
            check($sformatf("vec%0d_mm0", i), {63'd0, bus.rd_mismatch[0]}, {63'd0, vec[i].m0});
            check($sformatf("vec%0d_mm1", i), {63'd0, bus.rd_mismatch[1]}, {63'd0, vec[i].m1});
        end

        // ---------------- same-cycle write/read behaviour ------------------
        write_reg(5'd3, 32'h00000055);
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h00000077;
        set_ra(5'd0, 5'd3);
        #1;
`ifdef RF_BYPASS_EN
        check("byp_same_cycle", {32'd0, rd(1)}, {32'd0, 32'h00000077});
`else
        check("byp_same_cycle", {32'd0, rd(1)}, {32'd0, 32'h00000055});
`endif
        check("byp_same_mm", {63'd0, bus.rd_mismatch[1]}, 64'd0);
        tick();
        bus.we = 1'b0;
        #1;
        check("byp_after_edge", {32'd0, rd(1)}, {32'd0, 32'h00000077});

        // ---------------- scrubber repairs a single upset ------------------
        do_reset("rstA");
        write_reg(5'd7, 32'hA5A5A5A5);
        inject(2'd1, 5'd7, 32'h000000FF);
        set_ra(5'd7, 5'd0);
        #1;
        check("scrubA_pre_mm", {63'd0, bus.rd_mismatch[0]}, 64'd1);
        scrub_en = 1'b1;
        got = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            tick();
            if (bus.rd_mismatch[0] == 1'b0) begin
                got = 1;
                break;
            end
        end
        check("scrubA_cleared", 64'(got), 64'd1);
        check("scrubA_rd", {32'd0, rd(0)}, {32'd0, 32'hA5A5A5A5});
        check("scrubA_cnt", {56'd0, err_cnt}, 64'd1);
        repeat (2 * DEPTH + 2) tick();
        check("scrubA_cnt_sweep2", {56'd0, err_cnt}, 64'd1);
        check("scrubA_busy", {63'd0, scrub_busy}, 64'd1);
        scrub_en = 1'b0;
        wait_idle("scrubA");

        // ---------------- functional write beats scrub fix -----------------
        do_reset("rstB");
        write_reg(5'd9, 32'h00000055);
        inject(2'd0, 5'd9, 32'h0000000F);
        scrub_en = 1'b1;
        repeat (10) tick();
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h00000011;
        tick();
        bus.we = 1'b0;
        set_ra(5'd9, 5'd9);
        #1;
        check("fixB_rd", {32'd0, rd(0)}, {32'd0, 32'h00000011});
        check("fixB_mm", {63'd0, bus.rd_mismatch[0]}, 64'd0);
        check("fixB_cnt", {56'd0, err_cnt}, 64'd0);
        repeat (2 * DEPTH) tick();
        check("fixB_cnt_later", {56'd0, err_cnt}, 64'd0);
        scrub_en = 1'b0;
        wait_idle("fixB");

        // ---------------- correction counter saturation --------------------
        do_reset("rstC");
        scrub_en = 1'b1;
        fixes = 0;
        for (int i = 0; i < 300; i++) begin
            a = (i % 31) + 1;
            set_ra(5'(a), 5'd0);
            inject(2'(i % 3), 5'(a), $urandom() | 32'd1);
            #1;
            if (bus.rd_mismatch[0]) begin
                got = 0;
                for (int j = 0; j < 2 * DEPTH + 4; j++) begin
                    tick();
                    if (!bus.rd_mismatch[0]) begin
                        got = 1;
                        break;
                    end
                end
                check($sformatf("sat_fix%0d", i), 64'(got), 64'd1);
                if (got != 0) fixes++;
            end
            check($sformatf("sat_cnt%0d", i), {56'd0, err_cnt},
                  64'((fixes > 255) ? 255 : fixes));
        end
        check("sat_final", {56'd0, err_cnt}, 64'h00000000000000FF);
        scrub_en = 1'b0;
        wait_idle("satC");

        // ---------------- reset in the middle of a fix ---------------------
        do_reset("rstD0");
        write_reg(5'd2, 32'h00000022);
        write_reg(5'd3, 32'h00000033);
        inject(2'd0, 5'd2, 32'h00000001);
        inject(2'd1, 5'd3, 32'h00000002);
        scrub_en = 1'b1;
        repeat (5) tick();
        check("rstD_pre_cnt", {56'd0, err_cnt}, 64'd1);
        check("rstD_pre_busy", {63'd0, scrub_busy}, 64'd1);
        rst_in = 1'b0;
        set_ra(5'd2, 5'd3);
        #1;
        check("rstD_rd", {32'd0, bus.rdata}, 64'd0);
        check("rstD_mm", {62'd0, bus.rd_mismatch}, 64'd0);
        check("rstD_busy", {63'd0, scrub_busy}, 64'd0);
        check("rstD_cnt", {56'd0, err_cnt}, 64'd0);
        scrub_en = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
        tick();
        tick();
        check("rstD_after_rd", {32'd0, bus.rdata}, 64'd0);
        check("rstD_after_busy", {63'd0, scrub_busy}, 64'd0);

        // ---------------- randomized reads/writes/injections ---------------
        do_reset("rstR");
        for (int n = 0; n < 400; n++) begin
            bus.we    = 1'($urandom_range(0, 1));
            bus.waddr = 5'($urandom_range(0, 31));
            bus.wdata = $urandom();
            inj_en    = ($urandom_range(0, 2) != 0);
            inj_copy  = 2'($urandom_range(0, 3));
            inj_addr  = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
            inj_mask  = ($urandom_range(0, 1) != 0) ? $urandom() : (32'd1 << $urandom_range(0, 31));
            set_ra(($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)));
            @(negedge clk);
            for (int k = 0; k < NREAD; k++) begin
                a  = int'(bus.raddr[k*AW +: AW]);
                ev = m_vote(a);
                em = m_mm(a);
`ifdef RF_BYPASS_EN
                if (bus.we && int'(bus.waddr) == a && a != 0) begin
                    ev = bus.wdata;
                    em = 1'b0;
                end
`endif
                check($sformatf("rnd%0d_rd%0d", n, k), {32'd0, rd(k)}, {32'd0, ev});
                check($sformatf("rnd%0d_mm%0d", n, k), {63'd0, bus.rd_mismatch[k]}, {63'd0, em});
            end
            @(posedge clk);
            m_step(bus.we, int'(bus.waddr), bus.wdata, inj_en, int'(inj_copy),
                   int'(inj_addr), inj_mask);
            #1;
        end
        idle_inputs();

        // One scrub sweep must repair every disagreeing entry exactly once.
        nmm = 0;
        for (int e = 1; e < DEPTH; e++) if (m_mm(e)) nmm++;
        scrub_en = 1'b1;
        repeat (2 * DEPTH + nmm + 4) tick();
        scrub_en = 1'b0;
        wait_idle("rndsweep");
        for (int e = 1; e < DEPTH; e++) begin
            ev = m_vote(e);
            for (int c = 0; c < 3; c++) m_mem[c][e] = ev;
        end
        exp_err = (nmm > 255) ? 255 : nmm;
        check("rndsweep_cnt", {56'd0, err_cnt}, 64'(exp_err));
        for (int e = 0; e < DEPTH; e++) begin
            set_ra(5'(e), 5'(e));
            #1;
            check($sformatf("rndsweep_rd%0d", e), {32'd0, rd(0)}, {32'd0, m_vote(e)});
            check($sformatf("rndsweep_mm%0d", e), {63'd0, bus.rd_mismatch[0]}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
